// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two WIDTH-bit operands by pushing one 4-bit slice per cycle through a
// single 4-bit ripple-carry adder (RCA). The carry between slices is held in
// a register, so the combinational path is one RCA plus the slice muxes.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/cin presented
//   in_ready   block idle and able to take operands
//   a, b       WIDTH-bit operands (two's complement for ovf)
//   cin        carry into bit 0
//   out_valid  sum/cout/ovf hold a finished result
//   out_ready  consumer takes the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow
//   busy       an operation is in flight or waiting to be collected
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder built from full-adder cells.
module RCA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_reg;
    logic               ovf_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic [3:0]         rca_a;
    logic [3:0]         rca_b;
    logic [3:0]         rca_sum;
    logic               rca_cout;
    logic               accept;
    logic               last_nib;

    assign accept   = in_valid && (state_reg == IDLE);
    assign last_nib = (idx_reg == IDX_W'(NIB - 1));

    // Select the current operand slices for the shared adder.
    always_comb begin
        rca_a = '0;
        rca_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                rca_a = a_reg[4*i +: 4];
                rca_b = b_reg[4*i +: 4];
            end
        end
    end

    RCA u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_reg),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // Result register with only the active slice replaced.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_sum
            assign sum_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? rca_sum
                                                                 : sum_reg[4*gi +: 4];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid)  state_next = RUN;
            RUN:  if (last_nib)  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= rca_cout;
            if (last_nib) begin
                // Carry into the MSB equals a^b^sum at that bit.
                ovf_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ rca_sum[3] ^ rca_cout;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

    assign sum  = sum_reg;
    assign cout = carry_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          cin_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    // Narrow instance for the single-nibble case.
    logic          in_valid4 = 1'b0;
    logic          in_ready4;
    logic [3:0]    a4 = '0;
    logic [3:0]    b4 = '0;
    logic          cin4 = 1'b0;
    logic          out_valid4;
    logic          out_ready4 = 1'b1;
    logic [3:0]    sum4;
    logic          cout4;
    logic          ovf4;
    logic          busy4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a_in), .b(b_in), .cin(cin_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    // ---------------- behavioural model (WIDTH=16 instance) ----------------
    // phase: 0 = waiting for operands, 1 = computing, 2 = result offered.
    int           m_phase;
    int           m_left;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    logic [W:0] full;
                    full = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin_in};
                    m_sum   <= full[W-1:0];
                    m_cout  <= full[W];
                    m_ovf   <= (a_in[W-1] == b_in[W-1]) && (full[W-1] != a_in[W-1]);
                    m_left  <= NIB;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: advance to the falling edge and compare against the model.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
            chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
            if (m_phase == 2) begin
                chk("model_sum", {16'b0, sum}, {16'b0, m_sum});
                chk("model_cout", {31'b0, cout}, {31'b0, m_cout});
                chk("model_ovf", {31'b0, ovf}, {31'b0, m_ovf});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sum"}, {16'b0, sum}, 32'd0);
        chk({tag, "_cout"}, {31'b0, cout}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
    endtask

    // One operation with out_ready held high and hand-computed expectations.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int cyc;
        out_ready = 1'b1;
        a_in = av; b_in = bv; cin_in = cv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, NIB);
        chk("sum", {16'b0, sum}, {16'b0, es});
        chk("cout", {31'b0, cout}, {31'b0, ec});
        chk("ovf", {31'b0, ovf}, {31'b0, eo});
        $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d latency=%0d",
                 av, bv, cv, sum, cout, ovf, cyc);
        tick();
    endtask

    initial begin
        int cyc;

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held while new operands are offered and refused.
        out_ready = 1'b0;
        a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b0; in_valid = 1'b1;
        tick();
        a_in = 16'hAAAA; b_in = 16'h5555; cin_in = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_latency", cyc, NIB);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_sum", {16'b0, sum}, 32'h3333);
            chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_stall_in_ready", {31'b0, in_ready}, 32'd0);
            $display("stall %0d sum=%h out_valid=%0d in_ready=%0d", i, sum, out_valid, in_ready);
            tick();
        end
        out_ready = 1'b1;
        a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0;
        tick();
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_next_accepted", {31'b0, busy}, 32'd1);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_next_sum", {16'b0, sum}, 32'h0003);
        $display("post-stall op sum=%h latency=%0d", sum, cyc);
        tick();

        // Asynchronous reset in the middle of a carry chain.
        a_in = 16'hFFFF; b_in = 16'h0001; cin_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        $display("mid-run reset: in_ready=%0d busy=%0d sum=%h", in_ready, busy, sum);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Single-nibble instance.
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("w4_latency", cyc, 1);
        chk("w4_sum", {28'b0, sum4}, 32'h2);
        chk("w4_cout", {31'b0, cout4}, 32'd1);
        chk("w4_ovf", {31'b0, ovf4}, 32'd1);
        $display("w4 op a=9 b=8 cin=1 -> sum=%h cout=%0d ovf=%0d latency=%0d",
                 sum4, cout4, ovf4, cyc);
        tick();
        chk("w4_back_idle", {31'b0, in_ready4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide-operand adder that feeds the team's 4-bit ripple-carry adder `RCA`, one nibble per cycle. It accepts two WIDTH-bit operands over a valid/ready handshake and presents slice i to one internal `RCA` instance on cycle i, with the carry registered between slices. It collects the 4-bit sums into a result register and returns sum, carry-out and signed overflow over a second valid/ready handshake. Designs use it to add words wider than 4 bits while reusing a single 4-bit adder.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow (carry into MSB XOR cout).
- busy  output  1  high in RUN or DONE.

## Operation
- Exactly one internal 4-bit `RCA` instance. Its inputs are a_reg/b_reg nibble[idx] and carry_reg; its outputs drive the result nibble and the next carry.
- State machine: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch a→a_reg, b→b_reg, cin→carry_reg; clear idx; go to RUN.
  - RUN: each cycle write RCA sum into sum_reg[4*idx+3:4*idx] and RCA cout into carry_reg.
    - If idx < NIB-1: idx++.
    - If idx = NIB-1: also set ovf_reg = a_reg[W-1]^b_reg[W-1]^rca_sum[3]^rca_cout; go to DONE.
  - DONE: out_valid=1. On out_ready: go to IDLE.
- cout = carry_reg; ovf = ovf_reg; sum = sum_reg. These are valid only while out_valid=1. They stay stable from entry to DONE until the next accept.
- in_ready is low in RUN and DONE. in_valid is ignored there; no queuing.
- in_valid and out_ready are independent. A new operand is not accepted in the DONE→IDLE handshake cycle.
- idx width: clog2(NIB), minimum 1 bit.
- Reset (rst_n low, any state, including mid-RUN): state=IDLE, idx=0, a_reg=b_reg=sum_reg=0, carry_reg=0, ovf_reg=0. Inputs are ignored while rst_n is low. No partial result survives.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Accept on edge E0. Nibbles are computed on edges E1..E_NIB. out_valid rises after edge E_NIB, so latency is NIB cycles.
- With out_ready held high, the result handshake completes on edge E_NIB+1. in_ready returns high after that edge, and the next accept can occur at E_NIB+2. Peak throughput is one operation per NIB+2 cycles.
- If out_ready is low, DONE holds indefinitely with outputs frozen. There is no timeout.
- Carry ripples only within one nibble per cycle. The critical path is one RCA plus the operand muxes.
- in_ready, out_valid and busy decode directly from state registers, with no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → carry propagates through all 4 nibble cycles. Result: sum=0x0000, cout=1, ovf=0.
- WIDTH=16, a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
  - Also a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - During the stall: out_valid, sum, cout and ovf stay stable; in_ready=0; new operands are not taken.
  - Raise out_ready: IDLE on the next edge, in_ready=1, and the next operand is accepted one cycle later.
- Assert rst_n low for 1 cycle after 2 RUN cycles of 0xFFFF+0x0001.
  - Outputs return to reset values immediately (asynchronous).
  - Then 0x0F0F+0xF0F0, cin=0 → sum=0xFFFF, cout=0, with no stale carry.
- WIDTH=4: a=0x9, b=0x8, cin=1 → sum=0x2, cout=1, ovf=1. Latency is 1 cycle.
